worker_pool_sched: RTL and testbench

//  Shares a pool of NUM_WORKERS worker instances between one packet source and one result sink.

---
 rtl/worker_pool_sched.sv | 127 ++++++++++++
 tb/tb_worker_pool_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/worker_pool_sched.sv
// Shares a pool of workers between one packet source and one result sink:
// round-robin dispatch of a single held packet, round-robin collection of results.
module worker_pool_sched #(
    parameter int PACKET_WIDTH        = 16,
    parameter int WORKER_RESULT_WIDTH = 16,
    parameter int NUM_WORKERS         = 4,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                                       CLK,
    input  logic                                       RST,
    input  logic                                       IN_VALID,
    input  logic [PACKET_WIDTH-1:0]                    IN_DATA,
    output logic                                       IN_READY,
    output logic [NUM_WORKERS-1:0]                     W_PC_VALID,
    output logic [PACKET_WIDTH-1:0]                    W_PC_DATA,
    input  logic [NUM_WORKERS-1:0]                     W_PC_READY,
    input  logic [NUM_WORKERS-1:0]                     W_WR_VALID,
    input  logic [NUM_WORKERS*WORKER_RESULT_WIDTH-1:0] W_WR_DATA,
    output logic [NUM_WORKERS-1:0]                     W_WR_READY,
    output logic                                       OUT_VALID,
    output logic [WORKER_RESULT_WIDTH-1:0]             OUT_DATA,
    input  logic                                       OUT_READY,
    output logic                                       POOL_IDLE,
    output logic [CNT_WIDTH-1:0]                       DISPATCH_CNT,
    output logic [CNT_WIDTH-1:0]                       RESULT_CNT
);

    localparam int PTR_W = $clog2(NUM_WORKERS);

    logic                           hold_valid;
    logic [PACKET_WIDTH-1:0]        hold_data;
    logic [PTR_W-1:0]               d_ptr;
    logic [PTR_W-1:0]               d_grant;
    logic                           d_found;
    logic                           in_fire;
    logic                           d_fire;
    logic [PTR_W-1:0]               c_ptr;
    logic [PTR_W-1:0]               c_grant;
    logic                           c_found;
    logic                           c_fire;
    logic                           out_free;
    logic [WORKER_RESULT_WIDTH-1:0] wr_data_arr [NUM_WORKERS];

    for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_unpack
        assign wr_data_arr[g] = W_WR_DATA[g*WORKER_RESULT_WIDTH +: WORKER_RESULT_WIDTH];
    end

    assign IN_READY  = !hold_valid;
    assign W_PC_DATA = hold_data;
    assign in_fire   = IN_VALID && !hold_valid;
    assign d_fire    = hold_valid && d_found;
    assign out_free  = !OUT_VALID || OUT_READY;
    assign c_fire    = out_free && c_found;

    // Both arbiters search upward from their pointer, wrapping at NUM_WORKERS.
    always_comb begin
        logic [PTR_W-1:0] d_idx;
        logic [PTR_W-1:0] c_idx;
        d_found = 1'b0;
        d_grant = '0;
        c_found = 1'b0;
        c_grant = '0;
        d_idx   = '0;
        c_idx   = '0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            d_idx = PTR_W'((int'(d_ptr) + k) % NUM_WORKERS);
            c_idx = PTR_W'((int'(c_ptr) + k) % NUM_WORKERS);
            if (!d_found && W_PC_READY[d_idx]) begin
                d_found = 1'b1;
                d_grant = d_idx;
            end
            if (!c_found && W_WR_VALID[c_idx]) begin
                c_found = 1'b1;
                c_grant = c_idx;
            end
        end
    end

    always_comb begin
        W_PC_VALID = '0;
        W_WR_READY = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            W_PC_VALID[i] = d_fire && (d_grant == PTR_W'(i));
            W_WR_READY[i] = c_fire && (c_grant == PTR_W'(i));
        end
    end

    // Holding register can never accept and dispatch in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            d_ptr        <= '0;
            DISPATCH_CNT <= '0;
        end else if (in_fire) begin
            hold_valid <= 1'b1;
            hold_data  <= IN_DATA;
        end else if (d_fire) begin
            hold_valid   <= 1'b0;
            d_ptr        <= (d_grant == PTR_W'(NUM_WORKERS - 1)) ? '0 : d_grant + PTR_W'(1);
            DISPATCH_CNT <= DISPATCH_CNT + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            c_ptr      <= '0;
            RESULT_CNT <= '0;
            POOL_IDLE  <= 1'b0;
        end else begin
            if (c_fire) begin
                OUT_VALID <= 1'b1;
                OUT_DATA  <= wr_data_arr[c_grant];
                c_ptr     <= (c_grant == PTR_W'(NUM_WORKERS - 1)) ? '0 : c_grant + PTR_W'(1);
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
            if (OUT_VALID && OUT_READY) begin
                RESULT_CNT <= RESULT_CNT + CNT_WIDTH'(1);
            end
            POOL_IDLE <= !hold_valid && !OUT_VALID && (&W_PC_READY) && !(|W_WR_VALID);
        end
    end

endmodule

// File: tb/tb_worker_pool_sched.sv
// Self-checking bench for worker_pool_sched: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model of the scheduler.
module tb_worker_pool_sched;

    localparam int N  = 4;
    localparam int PW = 16;
    localparam int RW = 16;
    localparam int CW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IN_VALID;
    logic [PW-1:0] IN_DATA;
    logic          IN_READY;
    logic [N-1:0]  W_PC_VALID;
    logic [PW-1:0] W_PC_DATA;
    logic [N-1:0]  W_PC_READY;
    logic [N-1:0]  W_WR_VALID;
    logic [N*RW-1:0] W_WR_DATA;
    logic [N-1:0]  W_WR_READY;
    logic          OUT_VALID;
    logic [RW-1:0] OUT_DATA;
    logic          OUT_READY;
    logic          POOL_IDLE;
    logic [CW-1:0] DISPATCH_CNT;
    logic [CW-1:0] RESULT_CNT;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    logic          m_hold_valid;
    logic [PW-1:0] m_hold_data;
    int            m_dptr;
    logic [CW-1:0] m_dcnt;
    logic          m_out_valid;
    logic [RW-1:0] m_out_data;
    int            m_cptr;
    logic [CW-1:0] m_rcnt;
    logic          m_idle;

    worker_pool_sched #(
        .PACKET_WIDTH(PW), .WORKER_RESULT_WIDTH(RW), .NUM_WORKERS(N), .CNT_WIDTH(CW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .W_PC_VALID(W_PC_VALID), .W_PC_DATA(W_PC_DATA), .W_PC_READY(W_PC_READY),
        .W_WR_VALID(W_WR_VALID), .W_WR_DATA(W_WR_DATA), .W_WR_READY(W_WR_READY),
        .OUT_VALID(OUT_VALID), .OUT_DATA(OUT_DATA), .OUT_READY(OUT_READY),
        .POOL_IDLE(POOL_IDLE), .DISPATCH_CNT(DISPATCH_CNT), .RESULT_CNT(RESULT_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic int first_from(int ptr, logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int dispatch_pick();
        return m_hold_valid ? first_from(m_dptr, W_PC_READY) : -1;
    endfunction

    function automatic int collect_pick();
        return (!m_out_valid || OUT_READY) ? first_from(m_cptr, W_WR_VALID) : -1;
    endfunction

    function automatic logic [N-1:0] onehot(int idx);
        logic [N-1:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    task automatic model_advance();
        int dg;
        int cg;
        if (RST) begin
            m_hold_valid = 1'b0; m_hold_data = '0; m_dptr = 0; m_dcnt = '0;
            m_out_valid = 1'b0; m_out_data = '0; m_cptr = 0; m_rcnt = '0; m_idle = 1'b0;
            return;
        end
        dg = dispatch_pick();
        cg = collect_pick();
        if (m_out_valid && OUT_READY) m_rcnt = m_rcnt + 1;
        m_idle = !m_hold_valid && !m_out_valid && (&W_PC_READY) && !(|W_WR_VALID);
        if (IN_VALID && !m_hold_valid) begin
            m_hold_valid = 1'b1;
            m_hold_data  = IN_DATA;
        end else if (dg >= 0) begin
            m_hold_valid = 1'b0;
            m_dptr       = (dg + 1) % N;
            m_dcnt       = m_dcnt + 1;
        end
        if (cg >= 0) begin
            m_out_valid = 1'b1;
            m_out_data  = W_WR_DATA[cg*RW +: RW];
            m_cptr      = (cg + 1) % N;
        end else if (OUT_READY) begin
            m_out_valid = 1'b0;
        end
    endtask

    task automatic tick();
        model_advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; W_PC_READY = '0;
        W_WR_VALID = '0; W_WR_DATA = '0; OUT_READY = 1'b0;
        repeat (2) begin @(negedge CLK); tick(); end
        RST = 1'b0;
        @(negedge CLK);
        n_checks++; if (IN_READY !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_in_ready: got %b want 1", IN_READY); end
        n_checks++; if (OUT_VALID !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_out_valid: got %b want 0", OUT_VALID); end
        n_checks++; if (OUT_DATA !== '0) begin n_fails++; $display("[TB] FAIL reset_out_data: got %h want 0", OUT_DATA); end
        n_checks++; if (DISPATCH_CNT !== '0 || RESULT_CNT !== '0) begin n_fails++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", DISPATCH_CNT, RESULT_CNT); end
        n_checks++; if (POOL_IDLE !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_pool_idle: got %b want 0", POOL_IDLE); end
        n_checks++; if (W_PC_VALID !== '0 || W_WR_READY !== '0) begin n_fails++; $display("[TB] FAIL reset_handshakes: got pc %b wr %b want 0", W_PC_VALID, W_WR_READY); end
        tick();
    endtask

    task automatic test_dispatch_rr();
        W_PC_READY = 4'hF;
        for (int p = 0; p < 4; p++) begin
            IN_VALID = 1'b1;
            IN_DATA  = PW'(16'h000A + p);
            @(negedge CLK);
            n_checks++; if (IN_READY !== 1'b1) begin n_fails++; $display("[TB] FAIL rr_in_ready: got %b want 1", IN_READY); end
            tick();
            IN_VALID = 1'b0;
            @(negedge CLK);
            n_checks++; if (W_PC_VALID !== onehot(p)) begin n_fails++; $display("[TB] FAIL rr_grant: got %b want %b", W_PC_VALID, onehot(p)); end
            n_checks++; if (W_PC_DATA !== PW'(16'h000A + p)) begin n_fails++; $display("[TB] FAIL rr_data: got %h want %h", W_PC_DATA, 16'h000A + p); end
            n_checks++; if (IN_READY !== 1'b0) begin n_fails++; $display("[TB] FAIL rr_in_ready_hold: got %b want 0", IN_READY); end
            tick();
        end
        @(negedge CLK);
        n_checks++; if (DISPATCH_CNT !== CW'(4)) begin n_fails++; $display("[TB] FAIL rr_dispatch_cnt: got %0d want 4", DISPATCH_CNT); end
        tick();
    endtask

    task automatic test_single_ready();
        W_PC_READY = 4'b0100; IN_VALID = 1'b1; IN_DATA = 16'h0005;
        @(negedge CLK); tick();
        IN_VALID = 1'b0;
        @(negedge CLK);
        n_checks++; if (W_PC_VALID !== 4'b0100) begin n_fails++; $display("[TB] FAIL single_ready_grant: got %b want 0100", W_PC_VALID); end
        tick();
        W_PC_READY = 4'hF; IN_VALID = 1'b1; IN_DATA = 16'h0006;
        @(negedge CLK); tick();
        IN_VALID = 1'b0;
        @(negedge CLK);
        n_checks++; if (W_PC_VALID !== 4'b1000) begin n_fails++; $display("[TB] FAIL pointer_after_w2: got %b want 1000", W_PC_VALID); end
        tick();
    endtask

    task automatic test_dispatch_stall();
        W_PC_READY = '0; IN_VALID = 1'b1; IN_DATA = 16'h0077;
        @(negedge CLK); tick();
        IN_DATA = 16'h0099;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            n_checks++; if (IN_READY !== 1'b0 || W_PC_VALID !== '0) begin n_fails++; $display("[TB] FAIL stall_hold: got in_ready %b pc_valid %b want 0/0000", IN_READY, W_PC_VALID); end
            n_checks++; if (W_PC_DATA !== 16'h0077) begin n_fails++; $display("[TB] FAIL stall_data: got %h want 0077", W_PC_DATA); end
            tick();
        end
        IN_VALID = 1'b0; W_PC_READY = 4'b0010;
        @(negedge CLK);
        n_checks++; if (W_PC_VALID !== 4'b0010) begin n_fails++; $display("[TB] FAIL stall_release: got %b want 0010", W_PC_VALID); end
        tick();
        @(negedge CLK);
        n_checks++; if (W_PC_VALID !== '0 || IN_READY !== 1'b1) begin n_fails++; $display("[TB] FAIL stall_single_xfer: got pc %b in_ready %b want 0000/1", W_PC_VALID, IN_READY); end
        n_checks++; if (DISPATCH_CNT !== CW'(7)) begin n_fails++; $display("[TB] FAIL stall_dispatch_cnt: got %0d want 7", DISPATCH_CNT); end
        tick();
    endtask

    task automatic test_collect_rr();
        logic [RW-1:0] r [4];
        for (int i = 0; i < 4; i++) r[i] = RW'($urandom);
        OUT_READY = 1'b1; W_WR_VALID = 4'hF;
        W_WR_DATA = {r[3], r[2], r[1], r[0]};
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (c < 4) begin
                n_checks++; if (W_WR_READY !== onehot(c)) begin n_fails++; $display("[TB] FAIL collect_grant: got %b want %b", W_WR_READY, onehot(c)); end
            end
            if (c >= 1 && c <= 4) begin
                n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== r[c-1]) begin n_fails++; $display("[TB] FAIL collect_out: got %b/%h want 1/%h", OUT_VALID, OUT_DATA, r[c-1]); end
            end
            if (c == 5) begin
                n_checks++; if (OUT_VALID !== 1'b0) begin n_fails++; $display("[TB] FAIL collect_drain: got %b want 0", OUT_VALID); end
                n_checks++; if (RESULT_CNT !== CW'(4)) begin n_fails++; $display("[TB] FAIL collect_result_cnt: got %0d want 4", RESULT_CNT); end
            end
            tick();
            if (c < 4) W_WR_VALID[c] = 1'b0;
        end
    endtask

    task automatic test_out_stall();
        logic [RW-1:0] r4;
        logic [RW-1:0] r5;
        r4 = RW'($urandom); r5 = RW'($urandom);
        OUT_READY = 1'b0; W_WR_VALID = 4'b0011;
        W_WR_DATA = {RW'(0), RW'(0), r5, r4};
        @(negedge CLK);
        n_checks++; if (W_WR_READY !== 4'b0001) begin n_fails++; $display("[TB] FAIL ostall_first_grant: got %b want 0001", W_WR_READY); end
        tick();
        W_WR_VALID[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== r4) begin n_fails++; $display("[TB] FAIL ostall_hold: got %b/%h want 1/%h", OUT_VALID, OUT_DATA, r4); end
            n_checks++; if (W_WR_READY !== '0) begin n_fails++; $display("[TB] FAIL ostall_no_grant: got %b want 0000", W_WR_READY); end
            tick();
        end
        OUT_READY = 1'b1;
        @(negedge CLK);
        n_checks++; if (OUT_DATA !== r4 || W_WR_READY !== 4'b0010) begin n_fails++; $display("[TB] FAIL ostall_release: got %h/%b want %h/0010", OUT_DATA, W_WR_READY, r4); end
        tick();
        W_WR_VALID = '0;
        @(negedge CLK);
        n_checks++; if (OUT_VALID !== 1'b1 || OUT_DATA !== r5 || RESULT_CNT !== CW'(5)) begin n_fails++; $display("[TB] FAIL ostall_second: got %b/%h/%0d want 1/%h/5", OUT_VALID, OUT_DATA, RESULT_CNT, r5); end
        tick();
        @(negedge CLK);
        n_checks++; if (OUT_VALID !== 1'b0 || RESULT_CNT !== CW'(6)) begin n_fails++; $display("[TB] FAIL ostall_drain: got %b/%0d want 0/6", OUT_VALID, RESULT_CNT); end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_pc;
        logic [N-1:0] exp_wr;
        for (int c = 0; c < 300; c++) begin
            IN_VALID   = ($urandom_range(0, 2) != 0);
            IN_DATA    = PW'($urandom);
            W_PC_READY = N'($urandom);
            W_WR_VALID = N'($urandom & $urandom);
            W_WR_DATA  = {$urandom, $urandom};
            OUT_READY  = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            exp_pc = onehot(dispatch_pick());
            exp_wr = onehot(collect_pick());
            n_checks++; if (IN_READY !== !m_hold_valid) begin n_fails++; $display("[TB] FAIL rand_in_ready: got %b want %b", IN_READY, !m_hold_valid); end
            n_checks++; if (W_PC_VALID !== exp_pc) begin n_fails++; $display("[TB] FAIL rand_pc_valid: got %b want %b", W_PC_VALID, exp_pc); end
            if (m_hold_valid) begin
                n_checks++; if (W_PC_DATA !== m_hold_data) begin n_fails++; $display("[TB] FAIL rand_pc_data: got %h want %h", W_PC_DATA, m_hold_data); end
            end
            n_checks++; if (W_WR_READY !== exp_wr) begin n_fails++; $display("[TB] FAIL rand_wr_ready: got %b want %b", W_WR_READY, exp_wr); end
            n_checks++; if (OUT_VALID !== m_out_valid || OUT_DATA !== m_out_data) begin n_fails++; $display("[TB] FAIL rand_out: got %b/%h want %b/%h", OUT_VALID, OUT_DATA, m_out_valid, m_out_data); end
            n_checks++; if (DISPATCH_CNT !== m_dcnt || RESULT_CNT !== m_rcnt) begin n_fails++; $display("[TB] FAIL rand_counters: got %0d/%0d want %0d/%0d", DISPATCH_CNT, RESULT_CNT, m_dcnt, m_rcnt); end
            n_checks++; if (POOL_IDLE !== m_idle) begin n_fails++; $display("[TB] FAIL rand_pool_idle: got %b want %b", POOL_IDLE, m_idle); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        IN_VALID = 1'b1; IN_DATA = 16'h0042; W_PC_READY = '0;
        W_WR_VALID = 4'b0001; W_WR_DATA = {$urandom, $urandom}; OUT_READY = 1'b0;
        repeat (2) begin @(negedge CLK); tick(); end
        @(negedge CLK);
        n_checks++; if (IN_READY !== 1'b0 || OUT_VALID !== 1'b1) begin n_fails++; $display("[TB] FAIL midrst_setup: got in_ready %b out_valid %b want 0/1", IN_READY, OUT_VALID); end
        RST = 1'b1; IN_VALID = 1'b0; W_WR_VALID = '0;
        tick();
        RST = 1'b0;
        @(negedge CLK);
        n_checks++; if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0 || OUT_DATA !== '0) begin n_fails++; $display("[TB] FAIL midrst_regs: got %b/%b/%h want 1/0/0", IN_READY, OUT_VALID, OUT_DATA); end
        n_checks++; if (DISPATCH_CNT !== '0 || RESULT_CNT !== '0) begin n_fails++; $display("[TB] FAIL midrst_counters: got %0d/%0d want 0/0", DISPATCH_CNT, RESULT_CNT); end
        n_checks++; if (POOL_IDLE !== 1'b0) begin n_fails++; $display("[TB] FAIL midrst_idle_low: got %b want 0", POOL_IDLE); end
        tick();
        W_PC_READY = 4'hF;
        @(negedge CLK);
        n_checks++; if (POOL_IDLE !== 1'b0) begin n_fails++; $display("[TB] FAIL midrst_idle_lag: got %b want 0", POOL_IDLE); end
        tick();
        @(negedge CLK);
        n_checks++; if (POOL_IDLE !== 1'b1) begin n_fails++; $display("[TB] FAIL midrst_idle_set: got %b want 1", POOL_IDLE); end
        tick();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_dispatch_rr();
        test_single_ready();
        test_dispatch_stall();
        test_collect_rr();
        test_out_stall();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
